svc_rv_io_console: RTL and testbench

// - MMIO console peripheral on the SoC io_* bus. It sits downstream of svc_rv_soc_sram in place of
//   a plain io memory.
// - CPU stores push bytes into a TX FIFO. The FIFO drains over a valid/ready byte stream to a

---
 rtl/svc_rv_io_console.sv | 121 ++++++++++++
 tb/tb_svc_rv_io_console.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_io_console.sv
// MMIO console: CPU stores push bytes into a TX FIFO drained over a valid/ready byte stream.
// Optional SVC_RV_IO_CONSOLE_ECHO_EN echoes each accepted byte with $write in simulation only.
module svc_rv_io_console #(
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drain_en;
  logic [31:0]   r_dropped;
  logic [31:0]   r_rdata;

  logic          w_push_req;
  logic          w_ctrl_wr;
  logic          w_full;
  logic          w_empty;
  logic          w_tx_valid;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_push_req = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
  assign w_ctrl_wr  = io_wen && (io_waddr[3:2] == 2'd2) && io_wstrb[0];
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_tx_valid = r_drain_en && !w_empty;
  assign w_pop      = w_tx_valid && tx_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push_ok;

  assign tx_valid = w_tx_valid;
  assign tx_data  = r_mem[r_rd_ptr];
  assign io_rdata = r_rdata;

  assign w_unused = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                      io_wdata[31:8], io_wstrb[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_en <= 1'b1;
      r_dropped  <= '0;
    end else begin
      if (w_ctrl_wr) r_drain_en <= io_wdata[0];
      if (w_drop && (r_dropped != 32'hFFFF_FFFF)) r_dropped <= r_dropped + 32'd1;
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_full;
    w_status[1]       = w_empty;
    w_status[8 +: CW] = r_count;
  end

  always_comb begin
    w_rdata = '0;
    case (io_raddr[3:2])
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {31'd0, r_drain_en};
      2'd3:    w_rdata = r_dropped;
      default: w_rdata = '0;
    endcase
  end

  // Registered before this cycle's write lands, so reads see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= w_rdata;
  end

`ifdef SVC_RV_IO_CONSOLE_ECHO_EN
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) $write("%c", io_wdata[7:0]);
  end
`endif
`endif

endmodule

// File: tb/tb_svc_rv_io_console.sv
// Bench for svc_rv_io_console: directed scenarios plus random traffic checked against a queue model.
module tb_svc_rv_io_console;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_q[$];
  bit          m_drain;
  logic [31:0] m_dropped;

  svc_rv_io_console #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  function automatic bit m_valid();
    return m_drain && (m_q.size() != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] ra);
    int n;
    n = m_q.size();
    case (ra)
      2'd1:    return (32'(n) << 8) | ((n == 0) ? 32'h2 : 32'h0) | ((n == DEPTH) ? 32'h1 : 32'h0);
      2'd2:    return {31'd0, m_drain};
      2'd3:    return m_dropped;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_drain   = 1'b1;
    m_dropped = 32'd0;
  endtask

  // One bus cycle: drive at negedge, check stream outputs, then check registered read data.
  task automatic step(input bit wen, input logic [1:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [1:0] ra, input bit rdy);
    logic [31:0] a;
    logic [31:0] exp_rd;
    bit pop;
    @(negedge clk);
    a = $urandom; a[3:2] = wa; io_waddr = a;
    a = $urandom; a[3:2] = ra; io_raddr = a;
    io_wen = wen; io_wdata = wd; io_wstrb = ws; tx_ready = rdy;
    #1;
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid()});
    if (m_valid()) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
    exp_rd = m_read(ra);
    pop = m_valid() && rdy;
    if (pop) void'(m_q.pop_front());
    if (wen && wa == 2'd0 && ws[0]) begin
      if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]);
      else if (m_dropped != 32'hFFFF_FFFF) m_dropped++;
    end
    if (wen && wa == 2'd2 && ws[0]) m_drain = wd[0];
    @(posedge clk);
    #1;
    chk($sformatf("rdata[%0d]", ra), io_rdata, exp_rd);
  endtask

  task automatic idle(input logic [1:0] ra, input bit rdy);
    step(1'b0, 2'd0, 32'd0, 4'h0, ra, rdy);
  endtask

  initial begin
    rst_n = 1'b0; io_wen = 1'b0; io_waddr = '0; io_raddr = '0;
    io_wdata = '0; io_wstrb = '0; tx_ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;

    // Reset values of all four offsets
    for (int k = 0; k < 4; k++) idle(2'(k), 1'b0);

    // "Hi" with the sink always ready
    step(1'b1, 2'd0, 32'h48, 4'h1, 2'd1, 1'b1);
    step(1'b1, 2'd0, 32'h69, 4'h1, 2'd1, 1'b1);
    idle(2'd1, 1'b1);
    idle(2'd1, 1'b1);

    // Overfill with a stalled sink
    for (int k = 0; k < 17; k++) step(1'b1, 2'd0, 32'(k), 4'h1, 2'd3, 1'b0);
    idle(2'd1, 1'b0);
    chk("full_status", io_rdata, 32'h1001);
    idle(2'd3, 1'b0);
    chk("dropped_one", io_rdata, 32'd1);

    // Push while full with a pop in the same cycle
    step(1'b1, 2'd0, 32'hAA, 4'h1, 2'd1, 1'b1);
    idle(2'd1, 1'b0);
    idle(2'd3, 1'b0);
    for (int k = 0; k < 18; k++) idle(2'd1, 1'b1);

    // Drain disabled holds the contents
    step(1'b1, 2'd2, 32'd0, 4'h1, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 32'hC0 + 32'(k), 4'h1, 2'd1, 1'b1);
    idle(2'd1, 1'b1);
    idle(2'd1, 1'b1);
    step(1'b1, 2'd2, 32'd1, 4'h1, 2'd2, 1'b1);
    for (int k = 0; k < 4; k++) idle(2'd1, 1'b1);

    // Ignored writes
    step(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, 2'd1, 1'b0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 2'd3, 1'b0);
    step(1'b1, 2'd0, 32'h55, 4'hE, 2'd1, 1'b0);
    step(1'b1, 2'd2, 32'h0, 4'hE, 2'd2, 1'b0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [1:0]  wa;
      logic [31:0] wd;
      wa = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (wa == 2'd2) wd[0] = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 2) != 0, wa, wd, 4'($urandom),
           2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6);
    end

    // Reset while draining a backlog
    step(1'b1, 2'd2, 32'd1, 4'h1, 2'd1, 1'b0);
    for (int k = 0; k < 12; k++) idle(2'd1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 2'd0, 32'h30 + 32'(k), 4'h1, 2'd1, 1'b0);
    idle(2'd1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_rdata", io_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    idle(2'd1, 1'b1);
    chk("post_rst_status", io_rdata, 32'h2);
    for (int k = 0; k < 3; k++) idle(2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
